// File: rtl/if_stage.sv
// Instruction fetch: owns the PC and IF/ID register, talks to a variable-latency imem via level req/rdy.
// Latency: rdy in cycle N -> IF/ID in N+1; stall parks one fetch in a hold buffer and drops imem_req until it drains.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OPC = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_plus2,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] pc_cur,
    output logic        fetch_stall,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetchState_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pcPlus2;
    } ifidEntry_t;

    fetchState_t state, stateNext;
    logic [15:0] pcQ, pcNext;
    logic [15:0] drainAddr, drainAddrNext;
    ifidEntry_t  ifidQ, ifidNext;
    ifidEntry_t  bufQ, bufNext;
    logic        ifidValidQ, ifidValidNext;
    logic        bufValid, bufValidNext;
    logic        complete, fetchDone, isHalt;

    // A parked instruction blocks new requests, so at most one fetch is ever in flight.
    assign imem_req    = (state != HALTED) && !bufValid;
    assign imem_addr   = (state == DRAIN) ? drainAddr : pcQ;
    assign complete    = imem_req && imem_rdy;
    assign fetchDone   = complete && (state == FETCH);
    assign isHalt      = (imem_data[15:12] == HALT_OPC);
    assign fetch_stall = imem_req && !imem_rdy;

    always_comb begin
        stateNext     = state;
        pcNext        = pcQ;
        drainAddrNext = drainAddr;
        ifidNext      = ifidQ;
        ifidValidNext = ifidValidQ;
        bufNext       = bufQ;
        bufValidNext  = bufValid;

        if (branch_taken) begin
            pcNext         = branch_target;
            ifidValidNext  = 1'b0;
            ifidNext.instr = 16'h0000;
            bufValidNext   = 1'b0;
            // A request that has not yet completed must still be answered; remember where to absorb it.
            if (imem_req && !imem_rdy) begin
                stateNext     = DRAIN;
                drainAddrNext = imem_addr;
            end else begin
                stateNext = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (fetchDone) begin
                        if (isHalt) begin
                            stateNext = HALTED;
                        end else begin
                            pcNext = pc_plus2;
                        end
                    end
                end
                DRAIN: begin
                    if (complete) begin
                        stateNext = FETCH;
                    end
                end
                default: begin
                end
            endcase

            if (stall) begin
                if (fetchDone) begin
                    bufNext      = {imem_data, pc_plus2};
                    bufValidNext = 1'b1;
                end
            end else if (bufValid) begin
                ifidNext      = bufQ;
                ifidValidNext = 1'b1;
                bufValidNext  = 1'b0;
            end else if (fetchDone) begin
                ifidNext      = {imem_data, pc_plus2};
                ifidValidNext = 1'b1;
            end else begin
                ifidValidNext  = 1'b0;
                ifidNext.instr = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pcQ        <= RESET_PC;
            drainAddr  <= 16'h0000;
            ifidQ      <= '0;
            ifidValidQ <= 1'b0;
            bufQ       <= '0;
            bufValid   <= 1'b0;
        end else begin
            state      <= stateNext;
            pcQ        <= pcNext;
            drainAddr  <= drainAddrNext;
            ifidQ      <= ifidNext;
            ifidValidQ <= ifidValidNext;
            bufQ       <= bufNext;
            bufValid   <= bufValidNext;
        end
    end

    assign pc_cur        = pcQ;
    assign ifid_instr    = ifidQ.instr;
    assign ifid_pc_plus2 = ifidQ.pcPlus2;
    assign ifid_valid    = ifidValidQ;
    assign halted        = (state == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: random memory latency, stalls and redirects; a program-order model predicts the IF/ID stream.
module tb_if_stage;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_plus2;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] pc_cur;
    logic        fetch_stall;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;

    if_stage #(.RESET_PC(RESET_PC), .HALT_OPC(4'hF)) dut (
        .clk(clk), .rst(rst), .pc_plus2(pc_plus2),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
        .pc_cur(pc_cur), .fetch_stall(fetch_stall),
        .ifid_instr(ifid_instr), .ifid_pc_plus2(ifid_pc_plus2), .ifid_valid(ifid_valid),
        .halted(halted)
    );

    always #5 clk = ~clk;
    assign pc_plus2 = pc_cur + 16'd2;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pp2;
    } exp_t;

    logic [15:0] mem [0:32767];
    exp_t        expQ[$];
    exp_t        monE;
    int          nChecks = 0;
    int          nPass = 0;
    int          nPops = 0;
    int          latLo = 0;
    int          latHi = 0;
    int          waitCnt = 0;
    bit          prevOut = 0;
    logic [15:0] prevAddr = 16'h0000;
    bit          pendBr = 0;
    logic [15:0] pendTgt = 16'h0000;
    logic [15:0] w;
    logic        found;
    logic        reqSeen;
    int          p0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: from a fetch start, ID sees words in program order up to and including a halt.
    function automatic void pushFrom(input logic [15:0] start);
        logic [15:0] a;
        exp_t e;
        a = start;
        expQ.delete();
        for (int n = 0; n < 512; n++) begin
            e.instr = mem[a[15:1]];
            e.pp2   = a + 16'd2;
            expQ.push_back(e);
            if (e.instr[15:12] == 4'hF) break;
            a = a + 16'd2;
        end
    endfunction

    task automatic drive_mem();
        if (!rst && imem_req) begin
            if (!prevOut) waitCnt = int'($urandom_range(latHi, latLo));
            if (waitCnt == 0) begin
                imem_rdy  = 1'b1;
                imem_data = mem[imem_addr[15:1]];
                prevOut   = 0;
            end else begin
                imem_rdy  = 1'b0;
                imem_data = 16'($urandom);
                waitCnt--;
                prevOut   = 1;
                prevAddr  = imem_addr;
            end
        end else begin
            imem_rdy  = rst ? 1'b0 : 1'($urandom);
            imem_data = 16'($urandom);
            prevOut   = 0;
        end
    endtask

    task automatic tick(input logic br, input logic [15:0] tgt, input logic st);
        @(posedge clk);
        #1;
        if (pendBr) begin
            pushFrom(pendTgt);
            pendBr = 0;
        end
        if (prevOut) begin
            chk("req_held", 32'(imem_req), 'h1);
            chk("addr_stable", 32'(imem_addr), 32'(prevAddr));
        end
        branch_taken  = br;
        branch_target = tgt;
        stall         = st;
        if (br) begin
            pendBr  = 1;
            pendTgt = tgt;
        end
        drive_mem();
        #1;
    endtask

    task automatic doReset(input logic st);
        rst = 1'b1;
        branch_taken = 1'b0;
        stall = 1'b0;
        imem_rdy = 1'b0;
        pendBr = 0;
        prevOut = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall = st;
        pushFrom(RESET_PC);
        drive_mem();
        #1;
    endtask

    // Monitor: ID consumes IF/ID when not stalled; a redirect removes whatever IF/ID held.
    always @(negedge clk) begin
        if (!rst) begin
            chk("fetch_stall", 32'(fetch_stall), 32'(imem_req & ~imem_rdy));
            if (halted) chk("halt_no_req", 32'(imem_req), 'h0);
            if (!ifid_valid) begin
                chk("bubble_zero", 32'(ifid_instr), 'h0);
            end else if (!stall || branch_taken) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    $display("FAIL unexpected_instr: got %h pc+2 %h, expected no instruction", ifid_instr, ifid_pc_plus2);
                end else begin
                    monE = expQ.pop_front();
                    chk("ifid_instr", 32'(ifid_instr), 32'(monE.instr));
                    chk("ifid_pc_plus2", 32'(ifid_pc_plus2), 32'(monE.pp2));
                    nPops++;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h7;
            mem[i] = w;
        end
        for (int i = 512; i < 1024; i++) begin
            if (($urandom % 24) == 0) mem[i] = {4'hF, 12'($urandom)};
        end
        mem[0]     = 16'h1111;
        mem[1]     = 16'h2222;
        mem['h10]  = 16'hF000;

        // Reset values and zero-wait streaming
        latLo = 0; latHi = 0;
        doReset(1'b0);
        chk("rst_pc", 32'(pc_cur), 'h0);
        chk("rst_valid", 32'(ifid_valid), 'h0);
        chk("rst_instr", 32'(ifid_instr), 'h0);
        chk("rst_pp2", 32'(ifid_pc_plus2), 'h0);
        chk("rst_halted", 32'(halted), 'h0);
        chk("rst_req", 32'(imem_req), 'h1);
        chk("rst_addr", 32'(imem_addr), 'h0);
        tick(1'b0, 16'h0, 1'b0);
        chk("zw_instr1", 32'(ifid_instr), 'h1111);
        chk("zw_pp2_1", 32'(ifid_pc_plus2), 'h0002);
        chk("zw_pc1", 32'(pc_cur), 'h0002);
        tick(1'b0, 16'h0, 1'b0);
        chk("zw_instr2", 32'(ifid_instr), 'h2222);
        chk("zw_pp2_2", 32'(ifid_pc_plus2), 'h0004);
        chk("zw_pc2", 32'(pc_cur), 'h0004);

        // Three wait states
        latLo = 3; latHi = 3;
        doReset(1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("wait_fetch_stall", 32'(fetch_stall), 'h1);
            chk("wait_bubble", 32'(ifid_valid), 'h0);
            chk("wait_addr", 32'(imem_addr), 'h0);
            tick(1'b0, 16'h0, 1'b0);
        end
        chk("wait_rdy", 32'(fetch_stall), 'h0);
        latLo = 0; latHi = 0;
        tick(1'b0, 16'h0, 1'b0);
        chk("wait_valid", 32'(ifid_valid), 'h1);
        chk("wait_instr", 32'(ifid_instr), 'h1111);

        // Stall with the first fetch parked in the hold buffer
        doReset(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0, 1'b1);
            chk("buf_req_off", 32'(imem_req), 'h0);
            chk("buf_pc_hold", 32'(pc_cur), 'h0002);
            chk("buf_ifid_empty", 32'(ifid_valid), 'h0);
        end
        tick(1'b0, 16'h0, 1'b0);
        tick(1'b0, 16'h0, 1'b0);
        chk("buf_release_instr", 32'(ifid_instr), 'h1111);
        chk("buf_release_pp2", 32'(ifid_pc_plus2), 'h0002);
        chk("buf_next_req", 32'(imem_req), 'h1);
        chk("buf_next_addr", 32'(imem_addr), 'h0002);

        // Redirect while the fetch to 0x0010 is still waiting
        doReset(1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, 16'h0, 1'b0);
        chk("drain_pre_pc", 32'(pc_cur), 'h000E);
        latLo = 3; latHi = 3;
        tick(1'b1, 16'h0040, 1'b0);
        latLo = 0; latHi = 0;
        tick(1'b0, 16'h0, 1'b0);
        chk("drain_flush", 32'(ifid_valid), 'h0);
        chk("drain_addr", 32'(imem_addr), 'h0010);
        chk("drain_pc", 32'(pc_cur), 'h0040);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_req && imem_addr == 16'h0040) found = 1'b1;
            else tick(1'b0, 16'h0, 1'b0);
        end
        chk("drain_target_req", 32'(found), 'h1);
        tick(1'b0, 16'h0, 1'b0);
        chk("drain_target_instr", 32'(ifid_instr), 32'(mem['h20]));

        // Halt at 0x0020, refetch it, then redirect out of HALTED
        doReset(1'b0);
        for (int i = 0; i < 40 && !halted; i++) tick(1'b0, 16'h0, 1'b0);
        chk("halt_flag", 32'(halted), 'h1);
        chk("halt_delivered", 32'(ifid_instr), 'hF000);
        chk("halt_valid", 32'(ifid_valid), 'h1);
        chk("halt_pc", 32'(pc_cur), 'h0020);
        reqSeen = 1'b0;
        repeat (5) begin
            tick(1'b0, 16'h0, 1'b0);
            if (imem_req) reqSeen = 1'b1;
        end
        chk("halt_quiet", 32'(reqSeen), 'h0);
        tick(1'b1, 16'h0020, 1'b0);
        tick(1'b0, 16'h0, 1'b0);
        chk("rehalt_resumed", 32'(halted), 'h0);
        for (int i = 0; i < 10 && !halted; i++) tick(1'b0, 16'h0, 1'b0);
        chk("rehalt_flag", 32'(halted), 'h1);
        chk("rehalt_pc", 32'(pc_cur), 'h0020);
        tick(1'b1, 16'h0100, 1'b0);
        tick(1'b0, 16'h0, 1'b0);
        chk("resume_halted", 32'(halted), 'h0);
        chk("resume_pc", 32'(pc_cur), 'h0100);
        chk("resume_req", 32'(imem_req), 'h1);
        chk("resume_addr", 32'(imem_addr), 'h0100);
        tick(1'b0, 16'h0, 1'b0);
        chk("resume_instr", 32'(ifid_instr), 32'(mem['h80]));

        // Redirect and stall together, then a wrap past 0xFFFE
        doReset(1'b0);
        repeat (3) tick(1'b0, 16'h0, 1'b0);
        chk("bs_valid_before", 32'(ifid_valid), 'h1);
        tick(1'b1, 16'h0200, 1'b1);
        tick(1'b0, 16'h0, 1'b0);
        chk("bs_flush", 32'(ifid_valid), 'h0);
        chk("bs_instr_zero", 32'(ifid_instr), 'h0);
        chk("bs_pc", 32'(pc_cur), 'h0200);
        chk("bs_no_buffer", 32'(imem_req), 'h1);
        tick(1'b1, 16'hFFFE, 1'b0);
        tick(1'b0, 16'h0, 1'b0);
        chk("wrap_pc", 32'(pc_cur), 'hFFFE);
        tick(1'b0, 16'h0, 1'b0);
        chk("wrap_pp2", 32'(ifid_pc_plus2), 'h0000);
        chk("wrap_instr", 32'(ifid_instr), 32'(mem['h7FFF]));
        chk("wrap_pc_next", 32'(pc_cur), 'h0000);

        // Random latency, stalls, redirects and one mid-run reset
        latLo = 0; latHi = 3;
        doReset(1'b0);
        p0 = nPops;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) doReset(1'b0);
            tick(($urandom % 40) == 0, 16'($urandom_range(1023, 0) * 2), ($urandom % 4) == 0);
        end
        chk("rand_progress", 32'((nPops - p0) > 100), 'h1);
        tick(1'b0, 16'h0, 1'b0);
        tick(1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
